// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the parametrised multi-read-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    WM_WORD     = 2'b00,
    WM_LUI      = 2'b01,
    WM_LO_MERGE = 2'b10,
    WM_HI_MERGE = 2'b11
  } wr_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned SP_IDX_DEF  = 29;
  localparam int unsigned SP_INIT_DEF = 252;

endpackage

// File: rtl/regfile_wr_merge.sv
// Combinational write-data former: new register value from old value, write data and mode.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_wr_data,
  input  wr_mode_e          i_mode,
  output logic [DATA_W-1:0] o_new
);

  localparam int unsigned H = DATA_W / 2;

  always_comb begin
    o_new = i_wr_data;
    case (i_mode)
      WM_WORD:     o_new = i_wr_data;
      WM_LUI:      o_new = {i_wr_data[H-1:0], {H{1'b0}}};
      WM_LO_MERGE: o_new = {i_old[DATA_W-1:H], i_wr_data[H-1:0]};
      WM_HI_MERGE: o_new = {i_wr_data[H-1:0], i_old[H-1:0]};
      default:     o_new = i_wr_data;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: rising-edge writes with merge modes, write-first bypass,
// and a post-reset sequencer that clears the array one entry per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned SP_IDX  = SP_IDX_DEF,
  parameter int unsigned SP_INIT = SP_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [1:0]               wr_mode,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_wr_acc;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_new;
  logic [DATA_W-1:0]   w_clr_val;

  assign w_wr_acc  = (r_state == ST_READY) && wr_en && (wr_addr != '0);
  assign w_old     = r_mem[wr_addr];
  assign w_clr_val = (r_cnt == ADDR_W'(SP_IDX)) ? DATA_W'(SP_INIT) : '0;
  assign ready     = (r_state == ST_READY);

  regfile_wr_merge #(.DATA_W(DATA_W)) u_merge (
    .i_old     (w_old),
    .i_wr_data (wr_data),
    .i_mode    (wr_mode_e'(wr_mode)),
    .o_new     (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // No reset on the array so it maps onto RAM; the clear sequence initialises it instead.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) r_mem[r_cnt] <= w_clr_val;
    else if (w_wr_acc)       r_mem[wr_addr] <= w_new;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] r_rd;

    assign w_ra = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_data[gi*DATA_W +: DATA_W] = r_rd;

    // Same-cycle write to the read address returns the merged value (write-first).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_rd <= '0;
      end else if (rd_en[gi]) begin
        if (w_ra == '0)                         r_rd <= '0;
        else if (w_wr_acc && (w_ra == wr_addr)) r_rd <= w_new;
        else                                    r_rd <= r_mem[w_ra];
      end
    end
  end

endmodule
